// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the restoring 64/32 divider.
package div_pkg;

    localparam int DIV_DW = 32;
    localparam int CNT_W  = $clog2(DIV_DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor when it fits.
module div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] divisor_i,
    output logic [DW-1:0] rem_o,
    output logic          q_o
);

    logic [DW:0] shifted;
    logic [DW:0] diff;

    // rem_i < divisor_i always holds, so diff[DW] is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = ~diff[DW];
        rem_o   = q_o ? diff[DW-1:0] : shifted[DW-1:0];
    end

endmodule

// File: rtl/div64x32.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per cycle.
module div64x32
    import div_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            overflow,
    output div_state_e      state_dbg_o
);

    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] dsr_q, dsr_d;
    logic [DW-1:0] quo_q, quo_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [DW-1:0] remainder_q, remainder_d;
    logic          overflow_q, overflow_d;

    logic          ovf_det;
    logic [DW-1:0] step_rem;
    logic          step_q;

    // Quotient fits in DW bits only when the upper dividend half is below the divisor.
    assign ovf_det = (divisor == '0) || (dividend[2*DW-1:DW] >= divisor);

    div_step #(.DW(DW)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ovf_det ? DONE : CALC;
            CALC:    if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        state_dbg_o = state_q;
    end

    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        quo_d       = quo_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d      = dividend[2*DW-1:DW];
                    dvd_d      = dividend[DW-1:0];
                    dsr_d      = divisor;
                    quo_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = ovf_det;
                    overflow_d = 1'b0;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                quo_d = {quo_q[DW-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                if (ovf_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = '0;
                    overflow_d  = 1'b1;
                end else begin
                    quotient_d  = quo_q;
                    remainder_d = rem_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quo_q       <= '0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quo_q       <= quo_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_div64x32.sv
// Bench for div64x32: cycle-level behavioural model plus directed literal cases and random operations.
module tb_div64x32;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        overflow;
    div_state_e  state_dbg;

    always #5 clk = ~clk;

    div64x32 #(.DW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .state_dbg_o (state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Arithmetic reference: {overflow, quotient, remainder}
    function automatic logic [64:0] ref_div(input logic [63:0] d, input logic [31:0] v);
        logic [63:0] q64;
        logic [63:0] r64;
        if (v == 32'd0 || d[63:32] >= v) return {1'b1, 32'hFFFF_FFFF, 32'h0};
        q64 = d / {32'h0, v};
        r64 = d % {32'h0, v};
        return {1'b0, q64[31:0], r64[31:0]};
    endfunction

    function automatic int ref_len(input logic [63:0] d, input logic [31:0] v);
        if (v == 32'd0 || d[63:32] >= v) return 1;
        return 33;
    endfunction

    // Model: busy lasts a fixed number of cycles after acceptance, results appear as it drops.
    int          model_left;
    logic [64:0] pend;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic        m_ov;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_left <= 0;
            pend       <= '0;
            m_q        <= '0;
            m_r        <= '0;
            m_ov       <= 1'b0;
        end else if (model_left == 0) begin
            if (start) begin
                pend       <= ref_div(dividend, divisor);
                model_left <= ref_len(dividend, divisor);
                m_ov       <= 1'b0;
            end
        end else begin
            model_left <= model_left - 1;
            if (model_left == 1) {m_ov, m_q, m_r} <= pend;
        end
    end

    always @(negedge clk) begin
        check("cycle", {busy, overflow, quotient, remainder}, {(model_left != 0), m_ov, m_q, m_r});
    end

    task automatic do_op(input logic [63:0] d, input logic [31:0] v);
        start    = 1'b1;
        dividend = d;
        divisor  = v;
        @(negedge clk);
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
    endtask

    task automatic wait_idle(output int len);
        len = 0;
        while (busy === 1'b1 && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    int len;
    logic [31:0] rv;
    logic [31:0] rh;

    initial begin
        #1;
        check("reset_state", {busy, overflow, quotient, remainder}, 66'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op(64'd65855247502543032, 32'd316007988);
        wait_idle(len);
        check("len_big", 66'(len), 66'd33);
        check("res_big", 66'({overflow, quotient, remainder}), 66'({1'b0, 32'd208397414, 32'd0}));

        do_op(64'd100, 32'd7);
        wait_idle(len);
        check("res_100_7", 66'({overflow, quotient, remainder}), 66'({1'b0, 32'd14, 32'd2}));
        do_op(64'd65855247502543037, 32'd316007988);
        wait_idle(len);
        check("len_b2b", 66'(len), 66'd33);
        check("res_b2b", 66'({overflow, quotient, remainder}), 66'({1'b0, 32'd208397414, 32'd5}));

        @(negedge clk);
        do_op(64'h0123_4567_89AB_CDEF, 32'd0);
        wait_idle(len);
        check("len_div0", 66'(len), 66'd1);
        check("res_div0", 66'({overflow, quotient, remainder}), 66'({1'b1, 32'hFFFF_FFFF, 32'h0}));
        do_op(64'h1_0000_0000, 32'd1);
        wait_idle(len);
        check("len_ovf", 66'(len), 66'd1);
        check("res_ovf", 66'({overflow, quotient, remainder}), 66'({1'b1, 32'hFFFF_FFFF, 32'h0}));

        do_op(64'd100, 32'd7);
        check("ovf_clear", 66'(overflow), 66'd0);
        repeat (9) @(negedge clk);
        start    = 1'b1;
        dividend = 64'd12345;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle(len);
        check("len_ignore", 66'(len + 10), 66'd33);
        check("res_ignore", 66'({overflow, quotient, remainder}), 66'({1'b0, 32'd14, 32'd2}));

        do_op(64'd65855247502543032, 32'd316007988);
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset", {busy, overflow, quotient, remainder}, 66'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(64'd100, 32'd7);
        wait_idle(len);
        check("len_post_rst", 66'(len), 66'd33);
        check("res_post_rst", 66'({overflow, quotient, remainder}), 66'({1'b0, 32'd14, 32'd2}));

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            case ($urandom_range(0, 9))
                0: begin rv = 32'd0; rh = $urandom; end
                1: begin rv = $urandom_range(1, 1000); rh = rv + $urandom_range(0, 5000); end
                2: begin rv = $urandom_range(1, 15); rh = $urandom_range(0, 32'(rv - 1)); end
                default: begin
                    rv = $urandom;
                    if (rv == 32'd0) rv = 32'd1;
                    rh = $urandom % rv;
                end
            endcase
            do_op({rh, $urandom}, rv);
            len = 0;
            while (busy === 1'b1 && len < 100) begin
                start    = ($urandom_range(0, 3) == 0);
                dividend = {$urandom, $urandom};
                divisor  = $urandom;
                len++;
                @(negedge clk);
            end
            start = 1'b0;
            check("rand_idle", 66'(busy), 66'd0);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
